sa_os_array_ctrl: RTL and testbench
===================================

Name: sa_os_array_ctrl

Overview:
Parametrised output-stationary systolic matrix-multiply engine with built-in input skewing, K-step accumulation, and a handshaked row-by-row result drain.
- Accepts one A vector (COLS lanes) and one B vector (ROWS lanes) per beat.
- Each PE(i,j) accumulates a_j*b_i over all beats of a tile, then the tile is streamed out one row per transfer.
- It is the next generation of the fixed 4x4 / 8-bit / 16-bit array, adding parameters, flow control, flush/drain sequencing and soft clear.

Parameters:
ROWS, 4, PE rows; B lane count; ≥2
COLS, 4, PE columns; A lane count; ≥2
DW, 8, operand width per lane
ACCW, 16, accumulator width per PE; must be ≥ 2*DW
RIDXW, 2, width of out_row_idx; equals clog2(ROWS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous soft clear/abort
in_valid  in  1  input beat valid
in_ready  out  1  engine accepts a beat
in_last  in  1  beat is last K-step of tile
in_a  in  COLS*DW  A lanes; lane 0 in MSBs
in_b  in  ROWS*DW  B lanes; lane 0 in MSBs
out_valid  out  1  result row valid
out_ready  in  1  consumer accepts row
out_row  out  COLS*ACCW  accumulators of row out_row_idx; column 0 in MSBs
out_row_idx  out  RIDXW  index of row presented
busy  out  1  high in any state but IDLE/FEED-with-no-beats

Behaviour:
Reset and clocking:
- Single clock domain: clk.
- rst_n is asynchronous active-low; all flops use async clear on rst_n low.
- Reset values: state=IDLE, all accumulators and skew/pipe regs 0, in_ready=1, out_valid=0, out_row=0, out_row_idx=0, busy=0.
- Reset mid-operation discards the tile with no output.

Datapath:
- Input skew: lane j of A is delayed j cycles before entering column j top; lane i of B is delayed i cycles before entering row i left edge.
- A flows down one PE per cycle; B flows right one PE per cycle.
- A cycle with no accepted beat injects zeros at the array edges, so bubbles do not change results.
- PE arithmetic: unsigned DW x DW product, zero-extended to ACCW, added to the accumulator.
- Accumulator wraps modulo 2^ACCW; there is no saturation.

FSM:
- IDLE/FEED (one state, FEED): in_ready=1. A beat transfers when in_valid & in_ready. busy=1 once the first beat of the tile is accepted.
- Transfer with in_last=1: move to FLUSH next cycle; in_ready=0.
- FLUSH: counter runs ROWS+COLS-1 cycles, so the last beat's product has reached PE(ROWS-1,COLS-1) and been accumulated. Then move to DRAIN.
- DRAIN: out_valid=1, out_row_idx starts at 0.
  - out_row is stable while out_valid & !out_ready.
  - On out_valid & out_ready, increment the index.
  - Handshake on row ROWS-1: zero all accumulators, out_valid=0, return to FEED with in_ready=1 the next cycle.
- Latency: first out_valid rises exactly ROWS+COLS cycles after the clock edge that accepts the in_last beat.
- Single-beat tile (in_last on first beat) is legal.
- clr=1 (any state): next cycle state=FEED, accumulators and pipes zeroed, out_valid=0, index=0. clr has priority over a same-cycle in_valid or out_ready handshake, and the beat is not accepted.
- in_a/in_b are ignored when no transfer occurs.
- in_ready does not depend combinationally on in_valid.
- out_valid does not depend combinationally on out_ready.

Optional Feature:
SA_SIGNED_EN
- Defined: operands are two's-complement signed; the product is sign-extended to ACCW before accumulation. Wrap modulo 2^ACCW is unchanged.
- Undefined: unsigned arithmetic as above.
- No port or timing change either way.

Test Plan:
1. Single-beat tile, in_a={1,2,3,4}, in_b={1,2,3,4}, in_last=1, out_ready=1 → first out_valid 8 cycles after accept; rows 0..3 = {1,2,3,4},{2,4,6,8},{3,6,9,12},{4,8,12,16}; idx 0..3; then in_ready=1.
2. Three beats with in_valid gaps of 0, 2 and 5 cycles, A={1,1,1,1}, B={2,2,2,2} each beat → every PE = 6, identical to a back-to-back run.
3. Wrap: two beats of A=all 255, B=all 255, ACCW=16 → every PE = 130050 mod 65536 = 64514 (0xFC02).
4. Backpressure: out_ready low 5 cycles at row 0, then high → row 0 value and idx=0 held stable; exactly 4 row transfers; in_ready stays 0 until after the last one.
5. clr asserted during FLUSH of a tile, then a fresh single-beat tile A={1,0,0,0}, B={1,0,0,0} → output only PE(0,0)=1, all others 0; no output from the aborted tile. Same check with rst_n pulsed low mid-DRAIN → out_valid drops asynchronously.
6. SA_SIGNED_EN defined, A lane0=0xFF (-1), B lane0=0x02 → PE(0,0)=0xFFFE. Undefined → 510 (0x01FE).

Source files
------------

// File: rtl/sa_os_array_ctrl.sv
// Output-stationary systolic matmul engine: skewed A/B injection, K-step accumulation, row drain.
// Define SA_SIGNED_EN for two's-complement operands (sign-extended products).
module sa_os_array_ctrl #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned ACCW  = 16,
    parameter int unsigned RIDXW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [COLS*DW-1:0]   in_a,
    input  logic [ROWS*DW-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLS*ACCW-1:0] out_row,
    output logic [RIDXW-1:0]     out_row_idx,
    output logic                 busy
);

    typedef enum logic [1:0] {StFeed, StFlush, StDrain} state_e;

    localparam int unsigned FlushLast = ROWS + COLS - 1;
    localparam int unsigned CntW      = $clog2(ROWS + COLS);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RIDXW-1:0]  idx_q, idx_d;
    logic              got_q, got_d;
    logic              beat;
    logic              acc_clr;

    logic [DW-1:0]     a_top  [COLS];
    logic [DW-1:0]     b_left [ROWS];
    logic [DW-1:0]     a_dn   [ROWS-1][COLS];
    logic [DW-1:0]     b_rt   [ROWS][COLS-1];
    logic [ACCW-1:0]   acc    [ROWS][COLS];

    assign beat        = in_valid & (state_q == StFeed) & ~clr;
    assign in_ready    = (state_q == StFeed);
    assign out_valid   = (state_q == StDrain);
    assign out_row_idx = idx_q;
    assign busy        = (state_q != StFeed) | got_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFeed;
            cnt_q   <= '0;
            idx_q   <= '0;
            got_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            got_q   <= got_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        got_d   = got_q;
        acc_clr = 1'b0;
        if (clr) begin
            state_d = StFeed;
            cnt_d   = '0;
            idx_d   = '0;
            got_d   = 1'b0;
            acc_clr = 1'b1;
        end else begin
            unique case (state_q)
                StFeed: begin
                    if (beat) begin
                        if (in_last) begin
                            state_d = StFlush;
                            cnt_d   = '0;
                            got_d   = 1'b0;
                        end else begin
                            got_d = 1'b1;
                        end
                    end
                end
                StFlush: begin
                    if (cnt_q == CntW'(FlushLast)) state_d = StDrain;
                    else cnt_d = cnt_q + 1'b1;
                end
                StDrain: begin
                    if (out_ready) begin
                        if (idx_q == RIDXW'(ROWS - 1)) begin
                            state_d = StFeed;
                            idx_d   = '0;
                            acc_clr = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = StFeed;
            endcase
        end
    end

    // Lane j of A sits behind j+1 registers; non-beat cycles inject zeros.
    for (genvar j = 0; j < COLS; j++) begin : g_askew
        logic [DW-1:0] sr [j+1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n || clr) begin
                for (int k = 0; k <= j; k++) sr[k] <= '0;
            end else begin
                sr[0] <= beat ? in_a[(COLS-1-j)*DW +: DW] : '0;
                for (int k = 1; k <= j; k++) sr[k] <= sr[k-1];
            end
        end
        assign a_top[j] = sr[j];
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_bskew
        logic [DW-1:0] sr [i+1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n || clr) begin
                for (int k = 0; k <= i; k++) sr[k] <= '0;
            end else begin
                sr[0] <= beat ? in_b[(ROWS-1-i)*DW +: DW] : '0;
                for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
            end
        end
        assign b_left[i] = sr[i];
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [DW-1:0]   a_in, b_in;
            logic [ACCW-1:0] prod, acc_q;

            if (i == 0) begin : g_at
                assign a_in = a_top[j];
            end else begin : g_ai
                assign a_in = a_dn[i-1][j];
            end
            if (j == 0) begin : g_bl
                assign b_in = b_left[i];
            end else begin : g_bi
                assign b_in = b_rt[i][j-1];
            end

`ifdef SA_SIGNED_EN
            logic signed [2*DW-1:0] prod_s;
            assign prod_s = $signed(a_in) * $signed(b_in);
            assign prod   = ACCW'(prod_s);
`else
            assign prod = ACCW'(a_in) * ACCW'(b_in);
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       acc_q <= '0;
                else if (acc_clr) acc_q <= '0;
                else              acc_q <= acc_q + prod;
            end
            assign acc[i][j] = acc_q;

            if (i < ROWS - 1) begin : g_down
                logic [DW-1:0] a_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n || clr) a_q <= '0;
                    else               a_q <= a_in;
                end
                assign a_dn[i][j] = a_q;
            end
            if (j < COLS - 1) begin : g_right
                logic [DW-1:0] b_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n || clr) b_q <= '0;
                    else               b_q <= b_in;
                end
                assign b_rt[i][j] = b_q;
            end
        end
    end

    always_comb begin
        out_row = '0;
        if (state_q == StDrain) begin
            for (int j = 0; j < COLS; j++) out_row[(COLS-1-j)*ACCW +: ACCW] = acc[idx_q][j];
        end
    end

endmodule

// File: tb/tb_sa_os_array_ctrl.sv
// Scoreboard bench for sa_os_array_ctrl at the default 4x4 / 8-bit / 16-bit configuration.
module tb_sa_os_array_ctrl;

    localparam int ROWS = 4, COLS = 4, DW = 8, ACCW = 16, RIDXW = 2;

    typedef struct packed {
        logic [RIDXW-1:0]     idx;
        logic [COLS*ACCW-1:0] row;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n, clr, in_valid, in_ready, in_last;
    logic [COLS*DW-1:0]   in_a;
    logic [ROWS*DW-1:0]   in_b;
    logic                 out_valid, out_ready, busy;
    logic [COLS*ACCW-1:0] out_row;
    logic [RIDXW-1:0]     out_row_idx;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   n_xfer = 0;
    int   lat;
    int   xfer0;

    sa_os_array_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW), .ACCW(ACCW), .RIDXW(RIDXW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_row_idx(out_row_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_row(input int idx, input logic [15:0] c0, input logic [15:0] c1,
                            input logic [15:0] c2, input logic [15:0] c3);
        exp_t e;
        e.idx = RIDXW'(idx);
        e.row = {c0, c1, c2, c3};
        exp_q.push_back(e);
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        check("in_ready_before_beat", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'hA5A5A5A5;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Cycles from the accepting edge until out_valid is seen; 0 if it never rises.
    task automatic wait_valid(output int l);
        l = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
            check({name, "_in_ready_low_in_drain"}, 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        check({name, "_rows_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_in_ready_after"}, 64'(in_ready), 64'd1);
        check({name, "_out_valid_after"}, 64'(out_valid), 64'd0);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    // Monitor: compare every presented row that is handshaken.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                n_xfer++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_row: idx %0d row %0h, expected no output",
                             out_row_idx, out_row);
                end else begin
                    e = exp_q.pop_front();
                    if (out_row_idx !== e.idx || out_row !== e.row) begin
                        fails++;
                        $display("FAIL row_%0d: got idx %0d row %0h, expected idx %0d row %0h",
                                 e.idx, out_row_idx, out_row, e.idx, e.row);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        idle(2);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_row", out_row, 64'd0);
        check("rst_idx", 64'(out_row_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: single-beat outer product
        push_row(0, 1, 2, 3, 4);
        push_row(1, 2, 4, 6, 8);
        push_row(2, 3, 6, 9, 12);
        push_row(3, 4, 8, 12, 16);
        send_beat(32'h01020304, 32'h01020304, 1'b1);
        check("t1_busy_after_last", 64'(busy), 64'd1);
        wait_valid(lat);
        check("t1_latency", 64'(lat), 64'd8);
        wait_drain("t1");

        // 2: three beats with bubbles of 0, 2, 5 cycles
        for (int r = 0; r < ROWS; r++) push_row(r, 6, 6, 6, 6);
        send_beat(32'h01010101, 32'h02020202, 1'b0);
        check("t2_busy_mid_tile", 64'(busy), 64'd1);
        idle(2);
        send_beat(32'h01010101, 32'h02020202, 1'b0);
        idle(5);
        send_beat(32'h01010101, 32'h02020202, 1'b1);
        wait_valid(lat);
        check("t2_latency", 64'(lat), 64'd8);
        wait_drain("t2");

        // 3: accumulator wrap, 2 * 255 * 255 mod 2^16
        for (int r = 0; r < ROWS; r++) push_row(r, 16'hFC02, 16'hFC02, 16'hFC02, 16'hFC02);
        send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_valid(lat);
        wait_drain("t3");

        // 4: backpressure at row 0
        out_ready = 1'b0;
        push_row(0, 5, 10, 15, 20);
        push_row(1, 6, 12, 18, 24);
        push_row(2, 7, 14, 21, 28);
        push_row(3, 8, 16, 24, 32);
        send_beat(32'h01020304, 32'h05060708, 1'b1);
        wait_valid(lat);
        check("t4_latency", 64'(lat), 64'd8);
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_hold_idx", 64'(out_row_idx), 64'd0);
            check("t4_hold_row", out_row, {16'd5, 16'd10, 16'd15, 16'd20});
            check("t4_hold_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        xfer0 = n_xfer;
        out_ready = 1'b1;
        wait_drain("t4");
        check("t4_xfer_count", 64'(n_xfer - xfer0), 64'd4);

        // 5a: clr during FLUSH aborts the tile; clr also beats a same-cycle beat in FEED
        send_beat(32'h09090909, 32'h09090909, 1'b1);
        idle(3);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("t5_clr_in_ready", 64'(in_ready), 64'd1);
        check("t5_clr_out_valid", 64'(out_valid), 64'd0);
        check("t5_clr_busy", 64'(busy), 64'd0);
        clr = 1'b1; in_valid = 1'b1; in_last = 1'b1;
        in_a = 32'h07070707; in_b = 32'h07070707;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("t5_clr_priority_in_ready", 64'(in_ready), 64'd1);
        check("t5_clr_priority_busy", 64'(busy), 64'd0);
        idle(12);
        push_row(0, 1, 0, 0, 0);
        for (int r = 1; r < ROWS; r++) push_row(r, 0, 0, 0, 0);
        send_beat(32'h01000000, 32'h01000000, 1'b1);
        wait_valid(lat);
        check("t5_latency", 64'(lat), 64'd8);
        wait_drain("t5");

        // 6: signedness of lane-0 product
`ifdef SA_SIGNED_EN
        push_row(0, 16'hFFFE, 0, 0, 0);
`else
        push_row(0, 16'h01FE, 0, 0, 0);
`endif
        for (int r = 1; r < ROWS; r++) push_row(r, 0, 0, 0, 0);
        send_beat(32'hFF000000, 32'h02000000, 1'b1);
        wait_valid(lat);
        wait_drain("t6");

        // 5b: asynchronous reset mid-DRAIN
        out_ready = 1'b0;
        send_beat(32'h01010101, 32'h01010101, 1'b1);
        wait_valid(lat);
        check("t5b_valid_before_reset", 64'(out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5b_async_out_valid", 64'(out_valid), 64'd0);
        check("t5b_async_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("t5b_out_row", out_row, 64'd0);
        check("t5b_idx", 64'(out_row_idx), 64'd0);
        check("t5b_busy", 64'(busy), 64'd0);
        idle(12);
        check("t5b_no_output", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
